// File: rtl/npu_arbiter_pkg.sv
// Shared types and helpers for the NPU resource arbiter.
// Holds the arbiter state enum and the grant-index width helper.
package npu_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   function automatic int ARB_ID_W(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/priority_encoder_npu.sv
// LSB-first priority encoder: index of the lowest set bit.
// Ports: i_vec request vector, o_idx winner index, o_valid any bit set.
module priority_encoder_npu
   import npu_arbiter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]             i_vec,
   output logic [ARB_ID_W(N)-1:0]   o_idx,
   output logic                     o_valid
);

   localparam int W = ARB_ID_W(N);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx   = W'(i);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_lock_arbiter_npu.sv
// Round-robin arbiter with grant locking and a beat cap per grant.
// Ports: clk, reset_n, req/req_last/res_ready in; grant_oh/grant_id/grant_valid/beat_fire/forced_release out.
module rr_lock_arbiter_npu
   import npu_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BEATS = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic                          res_ready,
   output logic [NUM_REQ-1:0]            grant_oh,
   output logic [ARB_ID_W(NUM_REQ)-1:0]  grant_id,
   output logic                          grant_valid,
   output logic                          beat_fire,
   output logic                          forced_release
);

   localparam int ID_W  = ARB_ID_W(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);
   localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NUM_REQ - 1);

   arb_state_t          r_state;
   logic [NUM_REQ-1:0]  r_grant_oh;
   logic [ID_W-1:0]     r_grant_id;
   logic [CNT_W-1:0]    r_cnt;
   logic [ID_W-1:0]     r_ptr;
   logic                r_forced;

   arb_state_t          w_state_nxt;
   logic [NUM_REQ-1:0]  w_grant_oh_nxt;
   logic [ID_W-1:0]     w_grant_id_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [ID_W-1:0]     w_ptr_nxt;
   logic                w_forced_nxt;

   logic                w_valid;
   logic                w_fire;
   logic                w_last;
   logic                w_cap;
   logic [NUM_REQ-1:0]  w_arb_req;
   logic [NUM_REQ-1:0]  w_mask;
   logic [ID_W-1:0]     w_m_idx;
   logic                w_m_valid;
   logic [ID_W-1:0]     w_u_idx;
   logic                w_u_valid;
   logic [ID_W-1:0]     w_win_id;
   logic [NUM_REQ-1:0]  w_win_oh;

   assign w_valid = |r_grant_oh;
   assign w_fire  = w_valid & req[r_grant_id] & res_ready;
   assign w_last  = req_last[r_grant_id];
   assign w_cap   = (r_cnt == CNT_LAST);

   // The current owner never competes on its own release.
   assign w_arb_req = (r_state == ARB_IDLE) ? req : (req & ~r_grant_oh);

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_mask[i] = (ID_W'(i) > r_ptr);
      end
   end

   priority_encoder_npu #(
      .N       (NUM_REQ)
   ) u_pe_masked (
      .i_vec   (w_arb_req & w_mask),
      .o_idx   (w_m_idx),
      .o_valid (w_m_valid)
   );

   priority_encoder_npu #(
      .N       (NUM_REQ)
   ) u_pe_unmasked (
      .i_vec   (w_arb_req),
      .o_idx   (w_u_idx),
      .o_valid (w_u_valid)
   );

   // Masked winner wraps to the unmasked one when nothing sits above ptr.
   assign w_win_id = w_m_valid ? w_m_idx : w_u_idx;
   assign w_win_oh = NUM_REQ'(1) << w_win_id;

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_oh_nxt = r_grant_oh;
      w_grant_id_nxt = r_grant_id;
      w_cnt_nxt      = r_cnt;
      w_ptr_nxt      = r_ptr;
      w_forced_nxt   = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_u_valid) begin
               w_state_nxt    = ARB_BUSY;
               w_grant_oh_nxt = w_win_oh;
               w_grant_id_nxt = w_win_id;
               w_cnt_nxt      = '0;
               w_ptr_nxt      = w_win_id;
            end
         end
         ARB_BUSY: begin
            if (w_fire) begin
               if (w_last || w_cap) begin
                  // A real last beat wins over the cap.
                  w_forced_nxt = w_cap & ~w_last;
                  w_cnt_nxt    = '0;
                  if (w_u_valid) begin
                     w_grant_oh_nxt = w_win_oh;
                     w_grant_id_nxt = w_win_id;
                     w_ptr_nxt      = w_win_id;
                  end else begin
                     w_state_nxt    = ARB_IDLE;
                     w_grant_oh_nxt = '0;
                     w_grant_id_nxt = '0;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt    = ARB_IDLE;
            w_grant_oh_nxt = '0;
            w_grant_id_nxt = '0;
            w_cnt_nxt      = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= ARB_IDLE;
         r_grant_oh <= '0;
         r_grant_id <= '0;
         r_cnt      <= '0;
         r_ptr      <= PTR_RST;
         r_forced   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant_oh <= w_grant_oh_nxt;
         r_grant_id <= w_grant_id_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ptr      <= w_ptr_nxt;
         r_forced   <= w_forced_nxt;
      end
   end

   assign grant_oh       = r_grant_oh;
   assign grant_id       = r_grant_id;
   assign grant_valid    = w_valid;
   assign beat_fire      = w_fire;
   assign forced_release = r_forced;

endmodule

// File: tb/tb_rr_lock_arbiter_npu.sv
// Directed bench for rr_lock_arbiter_npu (NUM_REQ=4, MAX_BEATS=4).
// Drives fixed vectors and compares against hand-computed grants.
module tb_rr_lock_arbiter_npu;

   logic       clk;
   logic       reset_n;
   logic [3:0] req;
   logic [3:0] req_last;
   logic       res_ready;
   logic [3:0] grant_oh;
   logic [1:0] grant_id;
   logic       grant_valid;
   logic       beat_fire;
   logic       forced_release;

   int n_total;
   int n_bad;

   rr_lock_arbiter_npu #(
      .NUM_REQ        (4),
      .MAX_BEATS      (4)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req            (req),
      .req_last       (req_last),
      .res_ready      (res_ready),
      .grant_oh       (grant_oh),
      .grant_id       (grant_id),
      .grant_valid    (grant_valid),
      .beat_fire      (beat_fire),
      .forced_release (forced_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
   endtask

   initial begin
      n_total   = 0;
      n_bad     = 0;
      reset_n   = 1'b0;
      req       = 4'b0000;
      req_last  = 4'b0000;
      res_ready = 1'b0;
      cyc();
      cyc();
      check("rst_oh", 32'(grant_oh), 32'h0);
      check("rst_id", 32'(grant_id), 32'h0);
      check("rst_valid", 32'(grant_valid), 32'h0);
      check("rst_forced", 32'(forced_release), 32'h0);
      check("rst_fire", 32'(beat_fire), 32'h0);

      // Two single-beat requesters back to back
      reset_n   = 1'b1;
      req       = 4'b0110;
      req_last  = 4'b1111;
      res_ready = 1'b1;
      cyc();
      check("bb_id1", 32'(grant_id), 32'h1);
      check("bb_oh1", 32'(grant_oh), 32'h2);
      check("bb_fire1", 32'(beat_fire), 32'h1);
      cyc();
      check("bb_id2", 32'(grant_id), 32'h2);
      check("bb_oh2", 32'(grant_oh), 32'h4);
      req = 4'b0100;
      #1;
      check("bb_fire2", 32'(beat_fire), 32'h1);
      cyc();
      req = 4'b0000;
      check("bb_idle", 32'(grant_valid), 32'h0);

      // Lock for a 4-beat burst, last on the capped beat, then rotation
      do_reset();
      req      = 4'b1111;
      req_last = 4'b0000;
      cyc();
      check("lk_grant0", 32'(grant_id), 32'h0);
      for (int b = 1; b <= 3; b++) begin
         cyc();
         check($sformatf("lk_hold%0d", b), 32'(grant_id), 32'h0);
      end
      req_last = 4'b0001;
      cyc();
      check("lk_next1", 32'(grant_id), 32'h1);
      check("lk_noforce", 32'(forced_release), 32'h0);
      req_last = 4'b1111;
      cyc();
      check("rot_2", 32'(grant_id), 32'h2);
      cyc();
      check("rot_3", 32'(grant_id), 32'h3);
      cyc();
      check("rot_0", 32'(grant_id), 32'h0);
      req = 4'b0000;
      #1;
      check("drop_nofire", 32'(beat_fire), 32'h0);
      cyc();
      check("drop_hold", 32'(grant_id), 32'h0);
      check("drop_valid", 32'(grant_valid), 32'h1);
      req = 4'b0001;
      cyc();
      req = 4'b0000;
      check("drop_idle", 32'(grant_valid), 32'h0);

      // Stalls: counter only moves on fires (ptr is now 0)
      req       = 4'b0010;
      req_last  = 4'b0000;
      res_ready = 1'b1;
      cyc();
      check("st_grant1", 32'(grant_id), 32'h1);
      cyc();
      res_ready = 1'b0;
      #1;
      check("st_nofire", 32'(beat_fire), 32'h0);
      cyc();
      check("st_hold_a", 32'(grant_id), 32'h1);
      cyc();
      check("st_hold_b", 32'(grant_valid), 32'h1);
      res_ready = 1'b1;
      cyc();
      check("st_id_a", 32'(grant_id), 32'h1);
      cyc();
      check("st_valid", 32'(grant_valid), 32'h1);
      check("st_noforce", 32'(forced_release), 32'h0);
      cyc();
      req = 4'b0000;
      check("st_forced", 32'(forced_release), 32'h1);
      check("st_idle", 32'(grant_valid), 32'h0);
      cyc();
      check("st_pulse1", 32'(forced_release), 32'h0);

      // Forced release of 2 hands over to 3, then 2 again (ptr is 1)
      req      = 4'b1100;
      req_last = 4'b1000;
      cyc();
      check("fr_grant2", 32'(grant_id), 32'h2);
      for (int b = 1; b <= 3; b++) begin
         cyc();
         check($sformatf("fr_hold%0d", b), 32'(grant_id), 32'h2);
      end
      cyc();
      check("fr_to3", 32'(grant_id), 32'h3);
      check("fr_pulse", 32'(forced_release), 32'h1);
      cyc();
      check("fr_back2", 32'(grant_id), 32'h2);
      check("fr_pulse_end", 32'(forced_release), 32'h0);

      // Reset during beat 2 of a burst
      cyc();
      reset_n = 1'b0;
      cyc();
      check("mr_oh", 32'(grant_oh), 32'h0);
      check("mr_valid", 32'(grant_valid), 32'h0);
      check("mr_forced", 32'(forced_release), 32'h0);
      reset_n  = 1'b1;
      req      = 4'b1111;
      req_last = 4'b1111;
      cyc();
      check("mr_first0", 32'(grant_id), 32'h0);
      check("mr_oh0", 32'(grant_oh), 32'h1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/rr_lock_arbiter_npu.md
# rr_lock_arbiter_npu

Round-robin arbiter with grant locking that shares one single-ported resource (a memory bank port or network injection port) among `NUM_REQ` requesters. A grant, once issued, stays locked to its owner until the owner's last beat, so that multi-beat transactions are not interleaved. Forced release after `MAX_BEATS` beats bounds starvation. Arbitration uses a masked/unmasked pair of LSB-priority encoders over the request vector.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥ 2.
- `MAX_BEATS`, 16: maximum accepted beats per grant before forced release; must be ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous reset, active-low.
- `req`  in  `NUM_REQ`  per-requester request; held high for the whole transaction.
- `req_last`  in  `NUM_REQ`  per-requester last-beat flag; sampled only on a fire.
- `res_ready`  in  1  shared resource accepts a beat this cycle.
- `grant_oh`  out  `NUM_REQ`  one-hot registered grant; all zeros when idle.
- `grant_id`  out  `$clog2(NUM_REQ)`  binary index of the owner; 0 when idle.
- `grant_valid`  out  1  a grant is active (`|grant_oh`).
- `beat_fire`  out  1  `grant_valid & req[grant_id] & res_ready`; one beat transferred.
- `forced_release`  out  1  single-cycle pulse on the fire that ends a grant because of `MAX_BEATS`.

## Operation
- Reset values: state IDLE; `grant_oh`=0, `grant_id`=0, `grant_valid`=0, `forced_release`=0; beat counter 0; round-robin pointer `ptr`=`NUM_REQ-1`, so requester 0 wins first.
- Arbitration function on a request vector R:
  - mask = bits strictly above `ptr`.
  - If R&mask≠0, winner = lowest set bit of R&mask; otherwise winner = lowest set bit of R.
- IDLE: if `|req`, register winner(`req`) into `grant_oh`/`grant_id`, clear the counter, set `ptr`=winner, and go to BUSY. Otherwise stay in IDLE.
- BUSY:
  - Each `beat_fire` increments the counter. Without a fire the grant holds and the counter holds; this includes the owner dropping `req` without a last beat.
  - Release occurs on a fire with `req_last[grant_id]`=1, or on a fire with counter==`MAX_BEATS-1`.
  - When the release is caused by the counter and `req_last` is 0, pulse `forced_release`. If `req_last` is 1 on that same beat, the release is normal and no pulse is issued.
- On release, re-arbitrate in the same cycle on R = `req` with the owner's bit cleared.
  - If R≠0, go BUSY→BUSY with the new winner registered (no bubble), clear the counter, and update `ptr`.
  - If R=0, go to IDLE with the grant cleared.
- A forced-released owner that keeps `req` high competes again at the next arbitration, at lowest round-robin priority.
- `req` changes from non-owners never affect an active grant.
- Counter width is `$clog2(MAX_BEATS+1)` bits. It never wraps, because release occurs at `MAX_BEATS-1`.

## Timing
- Request to grant: 1 cycle. `req` is high at edge N, and `grant_valid` is high after edge N+1 (registered).
- `beat_fire` is combinational from the registered grant and the inputs, in the same cycle.
- Last beat at edge N gives the new owner's grant after edge N+1, so back-to-back grants have no idle cycle.
- `forced_release` is registered and is high for exactly one cycle following the terminating fire.
- Reset asserted mid-burst: grant, counter and `ptr` return to reset values at the next edge. No pulse is generated.

## Structure
- Shared package `npu_arbiter_pkg`: state enum `arb_state_t` {ARB_IDLE, ARB_BUSY} and the width helper `ARB_ID_W(N)` = `$clog2(N)`.
- Instantiate the existing LSB-priority encoder `priority_encoder_npu` twice: once on the masked vector and once on the unmasked vector. Its `valid` output selects masked vs unmasked.
- No other sub-modules. Pointer, counter and FSM are local to this block.

## Test plan
- Reset then `req`=4'b0110, `req_last`=all 1, `res_ready`=1: grants go 1, then 2, one beat each, no idle cycle between them; IDLE after requests drop.
- Lock: requester 0 runs a 4-beat burst while `req`=4'b1111. `grant_id` stays 0 for 4 fires. Next owner is 1, then 2, then 3, then 0 (rotation).
- `res_ready` toggled 1,0,0,1 during a burst: the counter advances only on fires, and the grant holds through the stalls.
- `MAX_BEATS`=4, requester 2 never asserts last, requester 3 requesting: `forced_release` pulses once after the 4th fire and the grant moves to 3. Requester 2 is regranted only after 3 releases.
- Last beat coincides with the 4th beat (`MAX_BEATS`=4): normal release, `forced_release` stays 0.
- `reset_n` low during beat 2 of a burst: next cycle `grant_oh`=0 and state IDLE; the first grant after reset goes to requester 0 when `req`=4'b1111.
